// File: rtl/sensor_init_pkg.sv
// Shared definitions for the sensor initialisation sequencer: table entry
// kinds, sequencer state encoding and the layout of a table entry word.
package sensor_init_pkg;

  // What a table entry asks the sequencer to do
  typedef enum logic [1:0] {
    KIND_WRITE        = 2'd0,
    KIND_WRITE_VERIFY = 2'd1,
    KIND_DELAY        = 2'd2,
    KIND_END          = 2'd3
  } kind_t;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_WR_REQ,
    ST_WR_WAIT,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_DELAY,
    ST_DONE,
    ST_ERROR
  } state_t;

  // Entry word is {kind, addr, data} with data in the low bits
  localparam int KIND_W   = 2;
  localparam int DATA_LSB = 0;

  function automatic int addr_lsb(input int data_w);
    return DATA_LSB + data_w;
  endfunction

  function automatic int kind_lsb(input int addr_w, input int data_w);
    return DATA_LSB + data_w + addr_w;
  endfunction

  function automatic int entry_w(input int addr_w, input int data_w);
    return KIND_W + addr_w + data_w;
  endfunction

endpackage

// File: rtl/sensor_init_table.sv
// Registered ROM holding the power-up register sequence of one sensor.
// The word for tbl_index appears on tbl_entry one clock after the index.
module sensor_init_table
  import sensor_init_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 128,
  parameter int IDX_W  = $clog2(DEPTH),
  parameter int SENSOR = 0
)(
  input  logic                         clk,
  input  logic [IDX_W-1:0]             tbl_index,
  output logic [2+ADDR_W+DATA_W-1:0]   tbl_entry
);

  localparam int EW = entry_w(ADDR_W, DATA_W);

  function automatic logic [EW-1:0] mk(input kind_t k, input int a, input int d);
    return {k, ADDR_W'(a), DATA_W'(d)};
  endfunction

  // Per-sensor contents; unused slots read as END so a short table stops cleanly
  function automatic logic [EW-1:0] rom_word(input logic [IDX_W-1:0] idx);
    logic [EW-1:0] w;
    int i;
    i = int'(idx);
    w = mk(KIND_END, 0, 0);
    case (SENSOR)
      0: begin
        // soft reset, settle, then wake-up
        case (i)
          0:       w = mk(KIND_WRITE, 'h12, 'h80);
          1:       w = mk(KIND_DELAY, 0, 2);
          2:       w = mk(KIND_WRITE, 'h11, 'h80);
          default: w = mk(KIND_END, 0, 0);
        endcase
      end
      1: begin
        // reset, settle, configure and confirm mode registers
        case (i)
          0:       w = mk(KIND_WRITE,        'h01, 'h01);
          1:       w = mk(KIND_DELAY,        0,    5);
          2:       w = mk(KIND_WRITE_VERIFY, 'h20, 'h0F);
          3:       w = mk(KIND_WRITE,        'h21, 'h03);
          4:       w = mk(KIND_WRITE_VERIFY, 'h30, 'h80);
          default: w = mk(KIND_END, 0, 0);
        endcase
      end
      default: w = mk(KIND_END, 0, 0);
    endcase
    return w;
  endfunction

  // Registered read port
  always_ff @(posedge clk) begin
    tbl_entry <= rom_word(tbl_index);
  end

endmodule

// File: rtl/sensor_init_sequencer.sv
// Walks an external register table and replays it onto a register bus:
// plain writes, writes with read-back verification, timed delays, with a
// bounded number of retries per entry. done/error are sticky until the
// next start.
module sensor_init_sequencer
  import sensor_init_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 128,
  parameter int IDX_W     = $clog2(DEPTH),
  parameter int UNIT_CYC  = 100000,
  parameter int MAX_RETRY = 3
)(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  output logic [IDX_W-1:0]           tbl_index,
  input  logic [2+ADDR_W+DATA_W-1:0] tbl_entry,
  output logic                       bus_req_valid,
  input  logic                       bus_req_ready,
  output logic                       bus_req_rw,
  output logic [ADDR_W-1:0]          bus_req_addr,
  output logic [DATA_W-1:0]          bus_req_wdata,
  input  logic                       bus_rsp_valid,
  input  logic                       bus_rsp_nack,
  input  logic [DATA_W-1:0]          bus_rsp_rdata,
  output logic                       busy,
  output logic                       done,
  output logic                       error,
  output logic [IDX_W-1:0]           err_index
);

  localparam int A_LSB = addr_lsb(DATA_W);
  localparam int K_LSB = kind_lsb(ADDR_W, DATA_W);

  // Delay counter must hold the largest data value times UNIT_CYC
  localparam longint DLY_MAX = ((longint'(1) << DATA_W) - 1) * longint'(UNIT_CYC);
  localparam int     DLY_W   = $clog2(DLY_MAX + 1);
  localparam int     RTY_W   = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  state_t             state;
  logic [RTY_W-1:0]   retry_cnt;
  logic [DLY_W-1:0]   dly_cnt;
  logic [DLY_W-1:0]   dly_load;

  kind_t              ent_kind;
  logic [ADDR_W-1:0]  ent_addr;
  logic [DATA_W-1:0]  ent_data;

  logic               cur_verify;
  logic [ADDR_W-1:0]  cur_addr;
  logic [DATA_W-1:0]  cur_data;

  logic               entry_ok;
  logic               entry_fail;

  assign ent_kind = kind_t'(tbl_entry[K_LSB +: KIND_W]);
  assign ent_addr = tbl_entry[A_LSB +: ADDR_W];
  assign ent_data = tbl_entry[DATA_LSB +: DATA_W];
  assign dly_load = DLY_W'(ent_data) * DLY_W'(UNIT_CYC);

  // Capture the decoded entry so retries and read-back compare survive the table moving on
  always_ff @(posedge clk) begin
    if (state == ST_DECODE) begin
      cur_verify <= (ent_kind == KIND_WRITE_VERIFY);
      cur_addr   <= ent_addr;
      cur_data   <= ent_data;
    end
  end

  // Decide whether the current entry finished successfully or needs a retry this cycle
  always_comb begin
    entry_ok   = 1'b0;
    entry_fail = 1'b0;
    case (state)
      ST_DECODE:  entry_ok = (ent_kind == KIND_DELAY) && (ent_data == '0);
      ST_WR_WAIT: begin
        if (bus_rsp_valid) begin
          if (bus_rsp_nack) entry_fail = 1'b1;
          else              entry_ok   = !cur_verify;
        end
      end
      ST_RD_WAIT: begin
        if (bus_rsp_valid) begin
          if (!bus_rsp_nack && (bus_rsp_rdata == cur_data)) entry_ok   = 1'b1;
          else                                              entry_fail = 1'b1;
        end
      end
      ST_DELAY:   entry_ok = (dly_cnt <= DLY_W'(1));
      default: begin
        entry_ok   = 1'b0;
        entry_fail = 1'b0;
      end
    endcase
  end

  // Sequencer FSM with registered bus request and status outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      tbl_index     <= '0;
      bus_req_valid <= 1'b0;
      bus_req_rw    <= 1'b0;
      bus_req_addr  <= '0;
      bus_req_wdata <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      err_index     <= '0;
      retry_cnt     <= '0;
      dly_cnt       <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (start) begin
            tbl_index <= '0;
            done      <= 1'b0;
            error     <= 1'b0;
            retry_cnt <= '0;
            busy      <= 1'b1;
            state     <= ST_FETCH;
          end
        end
        // Table word for tbl_index is valid from the next cycle on
        ST_FETCH: state <= ST_DECODE;
        ST_DECODE: begin
          case (ent_kind)
            KIND_WRITE, KIND_WRITE_VERIFY: begin
              bus_req_valid <= 1'b1;
              bus_req_rw    <= 1'b0;
              bus_req_addr  <= ent_addr;
              bus_req_wdata <= ent_data;
              state         <= ST_WR_REQ;
            end
            KIND_DELAY: begin
              dly_cnt <= dly_load;
              state   <= ST_DELAY;
            end
            default: begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= ST_DONE;
            end
          endcase
        end
        ST_WR_REQ: begin
          if (bus_req_ready) begin
            bus_req_valid <= 1'b0;
            state         <= ST_WR_WAIT;
          end
        end
        ST_WR_WAIT: begin
          // Write accepted on a verify entry: read it back
          if (bus_rsp_valid && !bus_rsp_nack && cur_verify) begin
            bus_req_valid <= 1'b1;
            bus_req_rw    <= 1'b1;
            bus_req_addr  <= cur_addr;
            bus_req_wdata <= cur_data;
            state         <= ST_RD_REQ;
          end
        end
        ST_RD_REQ: begin
          if (bus_req_ready) begin
            bus_req_valid <= 1'b0;
            state         <= ST_RD_WAIT;
          end
        end
        ST_RD_WAIT: begin
        end
        ST_DELAY: begin
          if (dly_cnt != '0) dly_cnt <= dly_cnt - DLY_W'(1);
        end
        default: state <= ST_IDLE;
      endcase

      // Entry completion overrides the per-state transition above
      if (entry_ok) begin
        retry_cnt <= '0;
        dly_cnt   <= '0;
        if (tbl_index == LAST_IDX) begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= ST_DONE;
        end else begin
          tbl_index <= tbl_index + IDX_W'(1);
          state     <= ST_FETCH;
        end
      end else if (entry_fail) begin
        if (retry_cnt < RTY_W'(MAX_RETRY)) begin
          retry_cnt     <= retry_cnt + RTY_W'(1);
          bus_req_valid <= 1'b1;
          bus_req_rw    <= 1'b0;
          bus_req_addr  <= cur_addr;
          bus_req_wdata <= cur_data;
          state         <= ST_WR_REQ;
        end else begin
          err_index <= tbl_index;
          error     <= 1'b1;
          busy      <= 1'b0;
          state     <= ST_ERROR;
        end
      end
    end
  end

endmodule

// File: tb/tb_sensor_init_sequencer.sv
// Directed bench for sensor_init_sequencer with a transaction-level model
// of the expected bus request stream and final status.
module tb_sensor_init_sequencer;
  import sensor_init_pkg::*;

  localparam int ADDR_W = 8, DATA_W = 8, DEPTH = 16, IDX_W = 4;
  localparam int UNIT_CYC = 10, MAX_RETRY = 3;
  localparam int EW = 2 + ADDR_W + DATA_W;

  typedef struct packed {
    logic       rw;
    logic [7:0] addr;
    logic [7:0] wdata;
  } req_t;

  logic clk = 1'b0;
  logic rst_n, start;
  logic [IDX_W-1:0] tbl_index, err_index;
  logic [EW-1:0] tbl_entry, bench_q, hw_q;
  logic bus_req_valid, bus_req_ready, bus_req_rw;
  logic [7:0] bus_req_addr, bus_req_wdata;
  logic bus_rsp_valid, bus_rsp_nack;
  logic [7:0] bus_rsp_rdata;
  logic busy, done, error;

  int total = 0, bad = 0, cyc = 0;

  logic [EW-1:0] rom [DEPTH];
  logic use_hw;
  logic [7:0] mem [256];

  // bench knobs
  logic [7:0] nack_addr;
  int nack_n;
  logic force_en, rsp_hold, chk_en;
  logic [7:0] force_val;
  int spur_req;

  // model results and logs
  req_t exp_q[$];
  logic exp_done, exp_err;
  int exp_eidx;
  req_t hs_log[$];
  int hs_cyc[$];
  int ack_cyc[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) bench_q <= rom[tbl_index];
  assign tbl_entry = use_hw ? hw_q : bench_q;

  sensor_init_sequencer #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .IDX_W(IDX_W),
    .UNIT_CYC(UNIT_CYC), .MAX_RETRY(MAX_RETRY)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .tbl_index(tbl_index), .tbl_entry(tbl_entry),
    .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready),
    .bus_req_rw(bus_req_rw), .bus_req_addr(bus_req_addr), .bus_req_wdata(bus_req_wdata),
    .bus_rsp_valid(bus_rsp_valid), .bus_rsp_nack(bus_rsp_nack), .bus_rsp_rdata(bus_rsp_rdata),
    .busy(busy), .done(done), .error(error), .err_index(err_index)
  );

  sensor_init_table #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .IDX_W(IDX_W), .SENSOR(0)
  ) hw_table (
    .clk(clk), .tbl_index(tbl_index), .tbl_entry(hw_q)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [EW-1:0] mk(input int k, input int a, input int d);
    return {2'(k), 8'(a), 8'(d)};
  endfunction

  // Walk the table by its rules and list every request the bus must see
  task automatic build_model();
    int idx, nused;
    bit fin, ok;
    logic [1:0] k;
    logic [7:0] a, d;
    exp_q.delete();
    exp_done = 0; exp_err = 0; exp_eidx = 0;
    idx = 0; nused = 0; fin = 0;
    while (!fin) begin
      k = rom[idx][EW-1 -: 2];
      a = rom[idx][15:8];
      d = rom[idx][7:0];
      ok = 1;
      if (k == 2'd3) begin
        exp_done = 1; fin = 1;
      end else begin
        if (k == 2'd0 || k == 2'd1) begin
          for (int att = 0; att <= MAX_RETRY; att++) begin
            exp_q.push_back({1'b0, a, d});
            ok = !(a == nack_addr && nused < nack_n);
            if (!ok) nused++;
            if (ok && k == 2'd1) begin
              exp_q.push_back({1'b1, a, d});
              ok = ((force_en ? force_val : d) == d);
            end
            if (ok) break;
          end
        end
        if (!ok) begin
          exp_err = 1; exp_eidx = idx; fin = 1;
        end else if (idx == DEPTH - 1) begin
          exp_done = 1; fin = 1;
        end else begin
          idx++;
        end
      end
    end
  endtask

  // Bus device: one-cycle response after each handshake, nacks and read data per knobs
  initial begin : responder
    bit hs;
    req_t r;
    int nused_r, spur_done;
    bus_rsp_valid = 0; bus_rsp_nack = 0; bus_rsp_rdata = 0;
    nused_r = 0; spur_done = 0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    forever begin
      @(negedge clk);
      hs = bus_req_valid && bus_req_ready && rst_n;
      r = {bus_req_rw, bus_req_addr, bus_req_wdata};
      if (start) nused_r = 0;
      if (hs) begin
        hs_log.push_back(r);
        hs_cyc.push_back(cyc);
      end
      @(posedge clk);
      #1;
      bus_rsp_valid = 0; bus_rsp_nack = 0; bus_rsp_rdata = 0;
      if (hs && !rsp_hold) begin
        bus_rsp_valid = 1;
        if (!r.rw) begin
          if (r.addr == nack_addr && nused_r < nack_n) begin
            bus_rsp_nack = 1;
            nused_r++;
          end else begin
            mem[r.addr] = r.wdata;
            ack_cyc.push_back(cyc);
          end
        end else begin
          bus_rsp_rdata = force_en ? force_val : mem[r.addr];
        end
      end else if (spur_req != spur_done) begin
        spur_done++;
        bus_rsp_valid = 1;
        bus_rsp_nack  = 1;
      end
    end
  end

  // Per-cycle checks: request stream against the model, stall stability, status rules
  always @(negedge clk) begin : compare
    req_t e, p_req;
    bit p_v, p_r;
    if (chk_en && rst_n) begin
      if (bus_req_valid && bus_req_ready) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL extra_req actual=%0h required=none", {bus_req_rw, bus_req_addr, bus_req_wdata});
        end else begin
          e = exp_q.pop_front();
          if (e.rw) chk("req_read", {bus_req_rw, bus_req_addr}, {e.rw, e.addr});
          else      chk("req_write", {bus_req_rw, bus_req_addr, bus_req_wdata}, e);
        end
        chk("busy_during_req", busy, 1);
      end
      if (p_v && !p_r)
        chk("stall_hold", {bus_req_valid, bus_req_rw, bus_req_addr, bus_req_wdata}, {1'b1, p_req});
      if (done || error) chk("busy_when_finished", busy, 0);
      chk("done_error_excl", done & error, 0);
    end
    p_v   = bus_req_valid && rst_n && chk_en;
    p_r   = bus_req_ready;
    p_req = {bus_req_rw, bus_req_addr, bus_req_wdata};
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1; tick(1); start = 0;
  endtask

  task automatic wait_end(input string name, input int limit);
    for (int i = 0; i < limit; i++) begin
      if (done || error) break;
      tick(1);
    end
    chk({name, "_finished"}, done | error, 1);
    tick(2);
  endtask

  task automatic check_end(input string name);
    chk({name, "_done"}, done, exp_done);
    chk({name, "_error"}, error, exp_err);
    if (exp_err) chk({name, "_err_index"}, err_index, exp_eidx);
    chk({name, "_busy"}, busy, 0);
    chk({name, "_reqs_left"}, exp_q.size(), 0);
  endtask

  task automatic check_reset_vals(input string name);
    chk({name, "_tbl_index"}, tbl_index, 0);
    chk({name, "_valid"}, bus_req_valid, 0);
    chk({name, "_rw"}, bus_req_rw, 0);
    chk({name, "_addr"}, bus_req_addr, 0);
    chk({name, "_wdata"}, bus_req_wdata, 0);
    chk({name, "_busy"}, busy, 0);
    chk({name, "_done"}, done, 0);
    chk({name, "_error"}, error, 0);
    chk({name, "_err_index"}, err_index, 0);
  endtask

  task automatic clear_rom();
    for (int i = 0; i < DEPTH; i++) rom[i] = mk(3, 0, 0);
  endtask

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int base, abase, gap, n;
    rst_n = 0; start = 0; bus_req_ready = 1; use_hw = 0;
    nack_addr = 8'h00; nack_n = 0; force_en = 0; force_val = 8'h00;
    rsp_hold = 0; chk_en = 0; spur_req = 0;
    clear_rom();

    // reset state
    tick(3);
    check_reset_vals("reset");
    rst_n = 1;
    tick(1);
    chk_en = 1;
    spur_req++;
    tick(3);

    // demo table from the ROM: write, 2-unit delay, write, end
    clear_rom();
    rom[0] = mk(0, 'h12, 'h80); rom[1] = mk(2, 0, 2); rom[2] = mk(0, 'h11, 'h80);
    use_hw = 1;
    build_model();
    base = hs_log.size(); abase = ack_cyc.size();
    pulse_start();
    for (int i = 0; i < 50 && ack_cyc.size() == abase; i++) tick(1);
    tick(5);
    spur_req++;
    wait_end("t1", 400);
    check_end("t1");
    chk("t1_nreq", hs_log.size() - base, 2);
    if (hs_log.size() - base >= 2 && ack_cyc.size() > abase) begin
      chk("t1_addr0", hs_log[base].addr, 8'h12);
      chk("t1_addr1", hs_log[base+1].addr, 8'h11);
      gap = hs_cyc[base+1] - ack_cyc[abase];
      chk("t1_gap_20_30", (gap >= 20 && gap <= 30), 1);
    end
    use_hw = 0;

    // write-verify with matching read-back
    clear_rom();
    rom[0] = mk(1, 'h40, 'hD0);
    build_model();
    base = hs_log.size();
    pulse_start();
    wait_end("t2", 200);
    check_end("t2");
    chk("t2_nreq", hs_log.size() - base, 2);
    if (hs_log.size() - base >= 2) chk("t2_read", {hs_log[base+1].rw, hs_log[base+1].addr}, {1'b1, 8'h40});

    // write-verify with wrong read-back exhausts retries
    force_en = 1; force_val = 8'hC0;
    build_model();
    base = hs_log.size();
    pulse_start();
    wait_end("t3", 400);
    check_end("t3");
    chk("t3_nreq", hs_log.size() - base, 8);
    chk("t3_error", error, 1);
    chk("t3_err_index", err_index, 0);
    force_en = 0;

    // two nacks on entry 3 then success
    clear_rom();
    rom[0] = mk(0, 'h01, 'h11); rom[1] = mk(0, 'h02, 'h22); rom[2] = mk(0, 'h03, 'h33);
    rom[3] = mk(0, 'h04, 'h44); rom[4] = mk(0, 'h05, 'h55);
    nack_addr = 8'h04; nack_n = 2;
    build_model();
    base = hs_log.size();
    pulse_start();
    wait_end("t4", 400);
    check_end("t4");
    n = 0;
    for (int i = base; i < hs_log.size(); i++) if (hs_log[i].addr == 8'h04) n++;
    chk("t4_entry3_reqs", n, 3);
    chk("t4_nreq", hs_log.size() - base, 7);
    chk("t4_done", done, 1);
    nack_n = 0;

    // ready held low for five cycles
    clear_rom();
    rom[0] = mk(0, 'h20, 'h5A);
    build_model();
    base = hs_log.size();
    bus_req_ready = 0;
    pulse_start();
    for (int i = 0; i < 20 && !bus_req_valid; i++) tick(1);
    for (int i = 0; i < 5; i++) begin
      chk("t5_stall_req", {bus_req_valid, bus_req_rw, bus_req_addr, bus_req_wdata}, {1'b1, 1'b0, 8'h20, 8'h5A});
      tick(1);
    end
    bus_req_ready = 1;
    wait_end("t5", 100);
    check_end("t5");
    chk("t5_nreq", hs_log.size() - base, 1);

    // full table without END, with a zero delay inside
    for (int i = 0; i < DEPTH; i++) rom[i] = mk(0, 'h50 + i, i);
    rom[5] = mk(2, 0, 0);
    build_model();
    base = hs_log.size();
    pulse_start();
    wait_end("t6", 800);
    check_end("t6");
    chk("t6_nreq", hs_log.size() - base, 15);
    if (hs_log.size() > base) chk("t6_last_addr", hs_log[hs_log.size()-1].addr, 8'h5F);

    // reset while waiting for a write response, then restart
    clear_rom();
    rom[0] = mk(0, 'h30, 'h01); rom[1] = mk(0, 'h31, 'h02);
    build_model();
    base = hs_log.size();
    rsp_hold = 1;
    pulse_start();
    for (int i = 0; i < 20 && hs_log.size() == base; i++) tick(1);
    tick(2);
    rst_n = 0;
    tick(1);
    check_reset_vals("t7_rst");
    tick(1);
    rst_n = 1;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus_req_valid) n++;
      tick(1);
    end
    chk("t7_no_req_after_rst", n, 0);
    chk("t7_nreq_aborted", hs_log.size() - base, 1);
    rsp_hold = 0;
    build_model();
    base = hs_log.size();
    pulse_start();
    for (int i = 0; i < 20 && hs_log.size() == base; i++) tick(1);
    pulse_start();
    wait_end("t7", 200);
    check_end("t7");
    chk("t7_nreq", hs_log.size() - base, 2);
    if (hs_log.size() > base) chk("t7_first_addr", hs_log[base].addr, 8'h30);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sensor_init_sequencer.md
SENSOR_INIT_SEQUENCER -- requirements
Module: sensor_init_sequencer

Interface
REQ-001 SHALL have parameters: ADDR_W, default 8, register-address width; DATA_W, default 8, register-data width; DEPTH, default 128, table entries; IDX_W, default clog2(DEPTH), index width; UNIT_CYC, default 100000, clocks per delay unit; MAX_RETRY, default 3, extra attempts per entry.
REQ-002 SHALL have ports: clk  in  1  system clock; rst_n  in  1  synchronous active-low reset.
REQ-003 SHALL have ports: start  in  1  begin sequence (pulse); tbl_index  out  IDX_W  table address; tbl_entry  in  2+ADDR_W+DATA_W  {kind[1:0], addr, data}, valid one cycle after tbl_index changes.
REQ-004 SHALL have ports: bus_req_valid  out  1; bus_req_ready  in  1; bus_req_rw  out  1  (0 write, 1 read); bus_req_addr  out  ADDR_W; bus_req_wdata  out  DATA_W.
REQ-005 SHALL have ports: bus_rsp_valid  in  1; bus_rsp_nack  in  1  no ACK from device; bus_rsp_rdata  in  DATA_W.
REQ-006 SHALL have ports: busy  out  1; done  out  1  sticky success; error  out  1  sticky failure; err_index  out  IDX_W  failing entry.

Function
REQ-007 Entry kinds SHALL be: 0 WRITE, 1 WRITE_VERIFY (write, read back, compare), 2 DELAY (data = wait in units), 3 END.
REQ-008 FSM states SHALL be IDLE, FETCH, DECODE, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT, DELAY, DONE, ERROR.
REQ-009 IDLE: start=1 -> tbl_index=0, clear done/error, retry count=0, go FETCH; busy=1 in all states except IDLE, DONE, ERROR.
REQ-010 FETCH SHALL last exactly one cycle; DECODE samples tbl_entry and branches by kind.
REQ-011 Bus request SHALL hold valid, rw, addr, wdata stable until the cycle bus_req_valid & bus_req_ready; then go to the matching WAIT state with valid=0.
REQ-012 WR_WAIT on bus_rsp_valid: nack=0 -> next entry (or RD_REQ for WRITE_VERIFY); nack=1 -> retry.
REQ-013 RD_WAIT on bus_rsp_valid: nack=0 and rdata==data -> next entry; otherwise retry.
REQ-014 Retry SHALL restart the entry at WR_REQ while retry count < MAX_RETRY, incrementing the count; else err_index=tbl_index, error=1, go ERROR.
REQ-015 DELAY SHALL wait data*UNIT_CYC clocks (data=0 -> zero wait), then next entry; counters sized so 255*UNIT_CYC does not overflow.
REQ-016 Next entry SHALL reset retry count, increment tbl_index, go FETCH; END or tbl_index==DEPTH-1 completed -> done=1, go DONE.
REQ-017 DONE/ERROR SHALL hold outputs; start re-runs from index 0; start while busy SHALL be ignored.
REQ-018 bus_rsp_valid outside a WAIT state SHALL be ignored.

Reset
REQ-019 With rst_n=0 at a clk edge: state=IDLE, tbl_index=0, bus_req_valid=0, rw/addr/wdata=0, busy=done=error=0, err_index=0, counters=0; reset mid-transaction SHALL abandon it without a further request.

Structure
REQ-020 Entry-kind encodings, state enum, and entry field offsets SHALL live in shared package sensor_init_pkg.
REQ-021 The table SHALL be a separate sub-module sensor_init_table (registered ROM, per-sensor contents); the sequencer contains no register values.

Verification
REQ-022 Table {WRITE 12/80, DELAY 2, WRITE 11/80, END}, UNIT_CYC=10, ready=1, ack -> two writes, >=20-cycle gap after first ack, done=1, error=0.
REQ-023 WRITE_VERIFY 40/D0, readback D0 -> write then read to addr 40, done=1; readback C0 -> 4 write+read attempts, error=1, err_index=0.
REQ-024 nack on first 2 attempts of entry 3, ack on third -> sequence completes, done=1, exactly 3 requests for entry 3.
REQ-025 bus_req_ready=0 for 5 cycles -> valid, addr, wdata stable for all 5 cycles; one handshake only.
REQ-026 rst_n=0 during WR_WAIT, then start -> all outputs at reset values, sequence restarts at index 0; start pulsed while busy -> ignored.
